// File: rtl/mem_pkg.sv
// Shared definitions for the byte-to-word memory port: FSM encoding and
// byte-offset to lane mapping.
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_RWAIT = 3'd2,
        ST_WR    = 3'd3,
        ST_RSP   = 3'd4
    } state_t;

    // Little-endian keeps the offset; big-endian mirrors it across the word.
    function automatic int unsigned lane_sel(input int unsigned ofs,
                                             input int unsigned bytes_per_word,
                                             input bit          big_endian);
        return big_endian ? (bytes_per_word - 1 - ofs) : ofs;
    endfunction

endpackage

// File: rtl/byte_lane_mux.sv
// Selects one byte lane out of a RAM word.
module byte_lane_mux #(
    parameter int BYTES_PER_WORD = 4,
    localparam int OFS_W = $clog2(BYTES_PER_WORD)
) (
    input  logic [8*BYTES_PER_WORD-1:0] word,
    input  logic [OFS_W-1:0]            lane,
    output logic [7:0]                  sel_byte
);

    assign sel_byte = word[{lane, 3'b000} +: 8];

endmodule

// File: rtl/byte_word_port.sv
// Byte-granular read/write port onto a word-wide synchronous RAM with one
// cycle of read latency; byte writes use native enables or read-modify-write.
module byte_word_port
    import mem_pkg::*;
#(
    parameter int BYTE_ADDR_WIDTH = 6,
    parameter int BYTES_PER_WORD  = 4,
    parameter bit BIG_ENDIAN      = 1'b0,
    parameter bit USE_BYTE_EN     = 1'b1,
    localparam int OFS_W   = $clog2(BYTES_PER_WORD),
    localparam int WORD_AW = BYTE_ADDR_WIDTH - OFS_W,
    localparam int WORD_W  = 8 * BYTES_PER_WORD
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [BYTE_ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]                 req_wdata,
    output logic                       rsp_valid,
    output logic [7:0]                 rsp_rdata,
    output logic                       word_rd_en,
    output logic                       word_wr_en,
    output logic [WORD_AW-1:0]         word_addr,
    output logic [BYTES_PER_WORD-1:0]  word_be,
    output logic [WORD_W-1:0]          word_wdata,
    input  logic [WORD_W-1:0]          word_rdata
);

    state_t             state, state_nxt;
    logic               accept;
    logic               a_we;
    logic [OFS_W-1:0]   a_ofs;
    logic [7:0]         a_wdata;
    logic [OFS_W-1:0]   req_lane, cur_lane;
    logic [7:0]         lane_byte;
    logic [WORD_W-1:0]  merged;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;

    assign req_lane = OFS_W'(lane_sel(32'(req_addr[OFS_W-1:0]), BYTES_PER_WORD, BIG_ENDIAN));
    assign cur_lane = OFS_W'(lane_sel(32'(a_ofs), BYTES_PER_WORD, BIG_ENDIAN));

    byte_lane_mux #(.BYTES_PER_WORD(BYTES_PER_WORD)) u_rsp_mux (
        .word     (word_rdata),
        .lane     (cur_lane),
        .sel_byte (lane_byte)
    );

    // RMW merge: every lane keeps the fetched byte except the addressed one.
    for (genvar j = 0; j < BYTES_PER_WORD; j++) begin : g_merge
        logic [7:0] old_byte;
        byte_lane_mux #(.BYTES_PER_WORD(BYTES_PER_WORD)) u_mux (
            .word     (word_rdata),
            .lane     (OFS_W'(j)),
            .sel_byte (old_byte)
        );
        assign merged[8*j +: 8] = (OFS_W'(j) == cur_lane) ? a_wdata : old_byte;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (req_valid) state_nxt = (req_we && USE_BYTE_EN) ? ST_WR : ST_RD;
            ST_RD:    state_nxt = ST_RWAIT;
            ST_RWAIT: state_nxt = a_we ? ST_WR : ST_RSP;
            ST_WR:    state_nxt = ST_RSP;
            ST_RSP:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            a_we       <= 1'b0;
            a_ofs      <= '0;
            a_wdata    <= '0;
            word_rd_en <= 1'b0;
            word_wr_en <= 1'b0;
            word_addr  <= '0;
            word_be    <= '0;
            word_wdata <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            state      <= state_nxt;
            word_rd_en <= (state_nxt == ST_RD);
            word_wr_en <= (state_nxt == ST_WR);
            rsp_valid  <= (state_nxt == ST_RSP);
            word_be    <= '0;
            if (accept) begin
                a_we      <= req_we;
                a_ofs     <= req_addr[OFS_W-1:0];
                a_wdata   <= req_wdata;
                word_addr <= req_addr[BYTE_ADDR_WIDTH-1:OFS_W];
            end
            if (state == ST_IDLE && state_nxt == ST_WR) begin
                word_be    <= BYTES_PER_WORD'(1) << req_lane;
                word_wdata <= {BYTES_PER_WORD{req_wdata}};
            end
            if (state == ST_RWAIT) begin
                if (a_we) begin
                    word_be    <= '1;
                    word_wdata <= merged;
                end else begin
                    rsp_rdata  <= lane_byte;
                end
            end
        end
    end

endmodule

// File: tb/tb_byte_word_port.sv
// Scoreboard bench for byte_word_port across all four endian / write-mode configurations.
module tb_byte_word_port;

    localparam int NW = 16;

    typedef struct { logic we; logic [5:0] addr; logic [7:0] wdata; bit hold; bit has_exp; logic [7:0] exp; } op_t;
    typedef struct { int cyc; logic [3:0] waddr; } rd_t;
    typedef struct { int cyc; logic [3:0] waddr; logic [3:0] be; logic [31:0] wdata; } wr_t;
    typedef struct { int cyc; logic [7:0] data; } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go  = 1'b0;
    logic go2 = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar C = 0; C < 4; C++) begin : g_cfg
        localparam int BEND = C / 2;
        localparam int UBE  = C % 2;

        logic        req_valid, req_ready, req_we, rsp_valid, word_rd_en, word_wr_en;
        logic [5:0]  req_addr;
        logic [7:0]  req_wdata, rsp_rdata;
        logic [3:0]  word_addr, word_be;
        logic [31:0] word_wdata, word_rdata;
        logic        ld_en;
        logic [3:0]  ld_addr;
        logic [31:0] ld_data;
        logic [31:0] mem [NW];
        logic [7:0]  refm [64];
        logic [7:0]  last_rd;
        logic        done = 1'b0;
        logic        fin  = 1'b0;
        rd_t  rq[$];
        wr_t  wq[$];
        rsp_t sq[$];
        op_t  ops[$];

        byte_word_port #(
            .BYTE_ADDR_WIDTH (6),
            .BYTES_PER_WORD  (4),
            .BIG_ENDIAN      (BEND[0]),
            .USE_BYTE_EN     (UBE[0])
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid),
            .req_ready  (req_ready),
            .req_we     (req_we),
            .req_addr   (req_addr),
            .req_wdata  (req_wdata),
            .rsp_valid  (rsp_valid),
            .rsp_rdata  (rsp_rdata),
            .word_rd_en (word_rd_en),
            .word_wr_en (word_wr_en),
            .word_addr  (word_addr),
            .word_be    (word_be),
            .word_wdata (word_wdata),
            .word_rdata (word_rdata)
        );

        // Word RAM with one cycle of read latency.
        always @(posedge clk) begin
            if (ld_en) mem[ld_addr] <= ld_data;
            if (word_wr_en)
                for (int k = 0; k < 4; k++)
                    if (word_be[k]) mem[word_addr][8*k +: 8] <= word_wdata[8*k +: 8];
            if (word_rd_en) word_rdata <= mem[word_addr];
        end

        initial begin : drv
            logic [31:0] v, wexp;
            int w, ln, t, n;
            op_t op;
            req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
            ld_en = 1'b0; ld_addr = '0; ld_data = '0; last_rd = 8'h00;
            for (int i = 0; i < NW; i++) begin
                v = (i == 0) ? 32'hDDCCBBAA : (i == 1) ? 32'h11223344 : $urandom;
                @(negedge clk); ld_en = 1'b1; ld_addr = 4'(i); ld_data = v;
                for (int k = 0; k < 4; k++) refm[i*4 + k] = v[8*(BEND != 0 ? 3 - k : k) +: 8];
            end
            @(negedge clk); ld_en = 1'b0;

            // Read that gets aborted by reset while waiting for RAM data.
            wait (go);
            req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd2;
            rq.push_back('{cyc + 1, 4'd0});
            @(posedge clk); #1 req_valid = 1'b0;
            wait (go2);

            ops.push_back('{1'b0, 6'h02, 8'h00, 1'b0, 1'b1, (BEND != 0) ? 8'hBB : 8'hCC});
            ops.push_back('{1'b0, 6'h00, 8'h00, 1'b0, 1'b1, (BEND != 0) ? 8'hDD : 8'hAA});
            ops.push_back('{1'b0, 6'h03, 8'h00, 1'b0, 1'b1, (BEND != 0) ? 8'hAA : 8'hDD});
            ops.push_back('{1'b1, 6'h07, 8'hEE, 1'b0, 1'b0, 8'h00});
            ops.push_back('{1'b0, 6'h07, 8'h00, 1'b0, 1'b1, 8'hEE});
            ops.push_back('{1'b1, 6'h05, 8'h5A, 1'b0, 1'b0, 8'h00});
            ops.push_back('{1'b0, 6'h05, 8'h00, 1'b0, 1'b1, 8'h5A});
            ops.push_back('{1'b1, 6'h3F, 8'h96, 1'b1, 1'b0, 8'h00});
            ops.push_back('{1'b0, 6'h3F, 8'h00, 1'b1, 1'b1, 8'h96});
            ops.push_back('{1'b0, 6'h3C, 8'h00, 1'b0, 1'b0, 8'h00});
            for (int i = 0; i < 200; i++)
                ops.push_back('{1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom),
                                1'($urandom_range(0, 1)), 1'b0, 8'h00});

            foreach (ops[i]) begin
                op = ops[i];
                req_valid = 1'b1; req_we = op.we; req_addr = op.addr; req_wdata = op.wdata;
                n = 0;
                while (!req_ready && n < 50) begin @(negedge clk); n++; end
                if (!req_ready) begin
                    errors++;
                    $display("FAIL cfg%0d accept_timeout: ready=%0b required 1", C, req_ready);
                    req_valid = 1'b0;
                    continue;
                end
                t  = cyc;
                w  = int'(op.addr) / 4;
                ln = (BEND != 0) ? 3 - (int'(op.addr) % 4) : int'(op.addr) % 4;
                if (!op.we) begin
                    rq.push_back('{t + 1, 4'(w)});
                    last_rd = op.has_exp ? op.exp : refm[op.addr];
                    sq.push_back('{t + 3, last_rd});
                end else begin
                    refm[op.addr] = op.wdata;
                    if (UBE != 0) begin
                        wq.push_back('{t + 1, 4'(w), 4'(1 << ln), {4{op.wdata}}});
                        sq.push_back('{t + 2, last_rd});
                    end else begin
                        for (int k = 0; k < 4; k++) wexp[8*(BEND != 0 ? 3 - k : k) +: 8] = refm[w*4 + k];
                        rq.push_back('{t + 1, 4'(w)});
                        wq.push_back('{t + 3, 4'(w), 4'hF, wexp});
                        sq.push_back('{t + 4, last_rd});
                    end
                end
                @(posedge clk); #1;
                if (!op.hold) begin
                    req_valid = 1'b0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
            req_valid = 1'b0;
            repeat (12) @(negedge clk);
            done = 1'b1;
        end

        always @(negedge clk) begin
            rd_t rd; wr_t wr; rsp_t rs;
            if (rst) begin
                checks++;
                if (!(req_ready && !word_rd_en && !word_wr_en && !rsp_valid &&
                      word_addr == 4'd0 && word_wdata == 32'd0 && rsp_rdata == 8'd0)) begin
                    errors++;
                    $display("FAIL cfg%0d reset_state: rdy=%0b rd=%0b wr=%0b rsp=%0b addr=%h wdata=%h rdata=%h required 1/0/0/0/0/0/0",
                             C, req_ready, word_rd_en, word_wr_en, rsp_valid, word_addr, word_wdata, rsp_rdata);
                end
            end else begin
                if (word_rd_en && word_wr_en) begin
                    checks++; errors++;
                    $display("FAIL cfg%0d both_strobes at cycle %0d", C, cyc);
                end
                if (word_rd_en) begin
                    checks++;
                    if (rq.size() == 0) begin
                        errors++; $display("FAIL cfg%0d rd_strobe: unexpected at cycle %0d", C, cyc);
                    end else begin
                        rd = rq.pop_front();
                        if (rd.cyc != cyc || rd.waddr != word_addr) begin
                            errors++;
                            $display("FAIL cfg%0d rd_strobe: cycle %0d addr %h required cycle %0d addr %h",
                                     C, cyc, word_addr, rd.cyc, rd.waddr);
                        end
                    end
                end
                if (word_wr_en) begin
                    checks++;
                    if (wq.size() == 0) begin
                        errors++; $display("FAIL cfg%0d wr_strobe: unexpected at cycle %0d", C, cyc);
                    end else begin
                        wr = wq.pop_front();
                        if (wr.cyc != cyc || wr.waddr != word_addr || wr.be != word_be || wr.wdata != word_wdata) begin
                            errors++;
                            $display("FAIL cfg%0d wr_strobe: cycle %0d addr %h be %b data %h required cycle %0d addr %h be %b data %h",
                                     C, cyc, word_addr, word_be, word_wdata, wr.cyc, wr.waddr, wr.be, wr.wdata);
                        end
                    end
                end
                if (rsp_valid) begin
                    checks++;
                    if (sq.size() == 0) begin
                        errors++; $display("FAIL cfg%0d rsp: unexpected at cycle %0d", C, cyc);
                    end else begin
                        rs = sq.pop_front();
                        if (rs.cyc != cyc || rs.data != rsp_rdata) begin
                            errors++;
                            $display("FAIL cfg%0d rsp: cycle %0d data %h required cycle %0d data %h",
                                     C, cyc, rsp_rdata, rs.cyc, rs.data);
                        end
                    end
                end
                if (done && !fin) begin
                    fin <= 1'b1;
                    checks++;
                    if (rq.size() != 0 || wq.size() != 0 || sq.size() != 0) begin
                        errors++;
                        $display("FAIL cfg%0d drain: pending rd %0d wr %0d rsp %0d required 0", C, rq.size(), wq.size(), sq.size());
                    end
                end
            end
        end
    end

    initial begin
        repeat (20) @(negedge clk);
        rst = 1'b0; go = 1'b1;
        // Two edges after acceptance every port sits in RWAIT.
        @(posedge clk); @(posedge clk); #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; go2 = 1'b1;
        for (int i = 0; i < 30000; i++) begin
            if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin) break;
            @(negedge clk);
        end
        if (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin)) begin
            checks++; errors++;
            $display("FAIL run_timeout: fin=%b%b%b%b required 1111",
                     g_cfg[3].fin, g_cfg[2].fin, g_cfg[1].fin, g_cfg[0].fin);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
